sdp_bram_pipe: RTL and testbench
================================

# sdp_bram_pipe

Parametrised simple dual-port block RAM: one write port, one read port, one clock. It extends the basic SDP BRAM with per-lane write enables, a configurable read pipeline with a valid flag, a selectable read/write collision mode, and a hardware clear sequencer. The sequencer zeroes memory after reset, so deep instances need no initial-block loops. It is the drop-in buffer for deep or timing-critical datapath stores.

## Interface
- ADDR_WIDTH, 11: address bits; DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 32: word width.
- LANE_WIDTH, 8: write-enable granularity; DATA_WIDTH % LANE_WIDTH must be 0 (elaboration error otherwise). NLANES = DATA_WIDTH/LANE_WIDTH.
- PIPE_DEPTH, 2: read latency in cycles, ≥1 (elaboration error if 0).
- COLLISION_MODE, 0: 0 = read-first (old data); 1 = write-first (new data bypassed).
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = skip clear.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ena  in  1  write port enable.
- wea  in  NLANES  per-lane write enable; bit i covers dina[i*LANE_WIDTH +: LANE_WIDTH].
- addra  in  ADDR_WIDTH  write address.
- dina  in  DATA_WIDTH  write data.
- enb  in  1  read request.
- addrb  in  ADDR_WIDTH  read address.
- doutb  out  DATA_WIDTH  read data; holds the last valid read.
- doutb_valid  out  1  doutb carries the data of a read issued PIPE_DEPTH cycles earlier.
- init_done  out  1  memory is ready; port accesses are honoured only while this is 1.

## Operation
- The FSM has two states, CLEAR and READY, plus a clear counter cnt[ADDR_WIDTH-1:0].
- On rst=1:
  - state goes to CLEAR (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0); cnt=0.
  - all pipeline valid bits go to 0, all pipeline data registers go to 0.
  - init_done goes to 0 (CLEAR) or 1 (READY).
- Memory contents are never reset directly.
- CLEAR: each edge with rst=0 writes 0 to ram[cnt] and increments cnt. The edge that writes cnt=DEPTH-1 moves to READY and sets init_done=1.
- In CLEAR, ena, wea, enb, addra, addrb and dina are ignored. No doutb_valid is generated.
- READY, write: for each lane i where ena & wea[i], ram[addra] lane i <= dina lane i. Other lanes keep their value.
- READY, read: enb=1 issues a read of ram[addrb] into pipeline stage 0, with valid bit v0=1.
- Pipeline:
  - PIPE_DEPTH stages; the valid bits shift every cycle.
  - A stage's data register loads only when its incoming valid is 1, otherwise it holds.
  - doutb = last stage data; doutb_valid = last stage valid.
- Collision (enb and a write to the same address in the same cycle):
  - COLLISION_MODE=0: stage 0 captures the pre-write word.
  - COLLISION_MODE=1: stage 0 captures the merged word (written lanes from dina, unwritten lanes from old content).
  - Memory receives the write in both modes.
- Back-to-back reads are accepted every cycle. There is no backpressure.
- Reset mid-operation:
  - In-flight reads are dropped (valid cleared).
  - A clear in progress restarts from cnt=0.
  - Writes on the rst=1 edge are ignored.

## Timing
- Read issued at edge k: doutb_valid=1 and doutb=data during the cycle after edge k+PIPE_DEPTH-1, i.e. latency PIPE_DEPTH.
- Write at edge k: visible to a read issued at edge k+1 in both modes, and at edge k itself only in mode 1.
- Clear duration: init_done rises after exactly DEPTH edges with rst=0 following reset.
- With CLEAR_ON_RESET=0, init_done=1 from the first edge with rst=1.
- Reset values: doutb=0, doutb_valid=0, init_done as above.
- A single-cycle enb produces exactly one single-cycle doutb_valid pulse.

## Test plan
Unless stated, ADDR_WIDTH=4, DATA_WIDTH=32, LANE_WIDTH=8, PIPE_DEPTH=2.
- Clear (CLEAR_ON_RESET=1): pre-load via write with CLEAR_ON_RESET forced; rst 3 cycles, release -> init_done=0 for 16 edges then 1; reads of addr 0..15 return 0x00000000; enb/ena during CLEAR produce no valid and no write.
- Basic write/read: write 0xDEADBEEF to addr 5; enb addr 5 at edge k -> doutb_valid=1, doutb=0xDEADBEEF after edge k+1 only; with PIPE_DEPTH=4, valid after edge k+3.
- Lane enables: addr 3 holds 0x11223344; write 0xAABBCCDD with wea=4'b0101 -> read returns 0x11BB33DD.
- Collision: addr 7 holds 0x0; same cycle write 0xCAFEF00D (wea=4'hF) and read addr 7 -> mode 0 returns 0x00000000, mode 1 returns 0xCAFEF00D; a follow-up read returns 0xCAFEF00D in both modes.
- Streaming/hold: enb for 16 consecutive cycles on addr 0..15 -> 16 consecutive valid beats in order; enb then low -> doutb holds the word from addr 15, doutb_valid=0.
- Reset mid-clear and mid-read:
  - rst pulse at cnt=9 -> clear restarts, init_done rises 16 edges after release.
  - rst with 2 reads in flight -> no doutb_valid pulses emerge, doutb=0.

Source files
------------

// File: rtl/sdp_bram_pipe.sv
// Simple dual-port block RAM with per-lane write enables, a configurable read
// pipeline, selectable collision behaviour and a post-reset clear sequencer.
module sdp_bram_pipe #(
  parameter  int ADDR_WIDTH     = 11,
  parameter  int DATA_WIDTH     = 32,
  parameter  int LANE_WIDTH     = 8,
  parameter  int PIPE_DEPTH     = 2,
  parameter  int COLLISION_MODE = 0,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int NLANES         = DATA_WIDTH / LANE_WIDTH,
  localparam int DEPTH          = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NLANES-1:0]     wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_valid,
  output logic                  init_done
);

  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
    $error("sdp_bram_pipe: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (PIPE_DEPTH < 1) begin : g_bad_pipe
    $error("sdp_bram_pipe: PIPE_DEPTH must be at least 1");
  end

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;

  logic                  clearing, ready, rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NLANES-1:0]     wr_lanes;
  logic [NLANES-1:0]     byp_mask;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word_q;
  logic [NLANES-1:0]     byp_mask_q, byp_mask_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
  logic                  v0_q, v0_d;
  logic [DATA_WIDTH-1:0] s0_word;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (rst) begin
      state_d     = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      cnt_d       = '0;
      init_done_d = (CLEAR_ON_RESET == 0);
    end else if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d     = S_READY;
        init_done_d = 1'b1;
      end
    end
  end

  // The clear sequencer owns the write port until the last word is zeroed.
  always_comb begin
    clearing = !rst && (state_q == S_CLEAR);
    ready    = !rst && (state_q == S_READY);
    rd_en    = ready && enb;
    wr_addr  = clearing ? cnt_q : addra;
    wr_data  = clearing ? '0 : dina;
    wr_lanes = '0;
    if (clearing)
      wr_lanes = '1;
    else if (ready && ena)
      wr_lanes = wea;
    byp_mask = '0;
    if (COLLISION_MODE != 0 && rd_en && (addra == addrb))
      byp_mask = wr_lanes;
    v0_d       = rd_en;
    byp_mask_d = rd_en ? byp_mask : byp_mask_q;
    byp_data_d = rd_en ? dina : byp_data_q;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (wr_lanes[i])
        ram[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // Registered read always sees the pre-write word; write-first is rebuilt below.
  always_ff @(posedge clk) begin
    if (rst)
      rd_word_q <= '0;
    else if (rd_en)
      rd_word_q <= ram[addrb];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      cnt_q       <= '0;
      init_done_q <= (CLEAR_ON_RESET == 0);
      v0_q        <= 1'b0;
      byp_mask_q  <= '0;
      byp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      v0_q        <= v0_d;
      byp_mask_q  <= byp_mask_d;
      byp_data_q  <= byp_data_d;
    end
  end

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign s0_word[gi*LANE_WIDTH +: LANE_WIDTH] = byp_mask_q[gi]
        ? byp_data_q[gi*LANE_WIDTH +: LANE_WIDTH]
        : rd_word_q[gi*LANE_WIDTH +: LANE_WIDTH];
  end

  if (PIPE_DEPTH == 1) begin : g_pipe1
    assign doutb       = s0_word;
    assign doutb_valid = v0_q;
  end else begin : g_pipen
    logic [PIPE_DEPTH-1:0]                 v_chain;
    logic [PIPE_DEPTH-1:0][DATA_WIDTH-1:0] d_chain;
    logic [PIPE_DEPTH-1:1]                 v_q, v_d;
    logic [PIPE_DEPTH-1:1][DATA_WIDTH-1:0] data_q, data_d;

    assign v_chain[0]              = v0_q;
    assign d_chain[0]              = s0_word;
    assign v_chain[PIPE_DEPTH-1:1] = v_q;
    assign d_chain[PIPE_DEPTH-1:1] = data_q;

    always_comb begin
      v_d    = v_chain[PIPE_DEPTH-2:0];
      data_d = data_q;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        if (v_chain[i-1])
          data_d[i] = d_chain[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q    <= '0;
        data_q <= '0;
      end else begin
        v_q    <= v_d;
        data_q <= data_d;
      end
    end

    assign doutb       = d_chain[PIPE_DEPTH-1];
    assign doutb_valid = v_chain[PIPE_DEPTH-1];
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_sdp_bram_pipe.sv
// Scoreboard bench: dut0 is read-first with clear and latency 2, dut1 is
// write-first without clear and latency 4.
module tb_sdp_bram_pipe;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        ena [2];
  logic [3:0]  wea [2];
  logic [3:0]  addra [2];
  logic [31:0] dina [2];
  logic        enb [2];
  logic [3:0]  addrb [2];
  logic [31:0] doutb [2];
  logic        doutb_valid [2];
  logic        init_done [2];

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   lat [2] = '{2, 4};
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdp_bram_pipe #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .LANE_WIDTH(8), .PIPE_DEPTH(2),
    .COLLISION_MODE(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst(rst[0]), .ena(ena[0]), .wea(wea[0]), .addra(addra[0]),
    .dina(dina[0]), .enb(enb[0]), .addrb(addrb[0]), .doutb(doutb[0]),
    .doutb_valid(doutb_valid[0]), .init_done(init_done[0])
  );

  sdp_bram_pipe #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .LANE_WIDTH(8), .PIPE_DEPTH(4),
    .COLLISION_MODE(1), .CLEAR_ON_RESET(0)
  ) dut1 (
    .clk(clk), .rst(rst[1]), .ena(ena[1]), .wea(wea[1]), .addra(addra[1]),
    .dina(dina[1]), .enb(enb[1]), .addrb(addrb[1]), .doutb(doutb[1]),
    .doutb_valid(doutb_valid[1]), .init_done(init_done[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic [31:0] data);
    exp_t e;
    e.data = data;
    e.due  = cyc + lat[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wr(input int d, input logic [3:0] a, input logic [3:0] we, input logic [31:0] data);
    ena[d] = 1'b1; wea[d] = we; addra[d] = a; dina[d] = data;
    step();
    ena[d] = 1'b0; wea[d] = 4'h0;
    $display("[TB] dut%0d write addr=%0d wea=%b data=%h", d, a, we, data);
  endtask

  task automatic rd(input int d, input logic [3:0] a, input logic [31:0] exp);
    enb[d] = 1'b1; addrb[d] = a;
    push(d, exp);
    step();
    enb[d] = 1'b0;
  endtask

  task automatic wr_rd(input int d, input logic [3:0] a, input logic [3:0] we,
                       input logic [31:0] data, input logic [31:0] exp);
    ena[d] = 1'b1; wea[d] = we; addra[d] = a; dina[d] = data;
    enb[d] = 1'b1; addrb[d] = a;
    push(d, exp);
    step();
    ena[d] = 1'b0; wea[d] = 4'h0; enb[d] = 1'b0;
    $display("[TB] dut%0d collide addr=%0d wea=%b data=%h", d, a, we, data);
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (doutb_valid[d] === 1'b1) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        tests++;
        fails++;
        $display("[TB] FAIL dut%0d unexpected_valid: got beat data=%h at cycle %0d, required no beat",
                 d, doutb[d], cyc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        $display("[TB] dut%0d read beat data=%h exp=%h cycle=%0d due=%0d", d, doutb[d], e.data, cyc, e.due);
        chk($sformatf("dut%0d_read_data", d), doutb[d], e.data);
        chk($sformatf("dut%0d_read_latency", d), cyc, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ena[d] = 1'b0; wea[d] = 4'h0; addra[d] = 4'h0;
      dina[d] = 32'h0; enb[d] = 1'b0; addrb[d] = 4'h0;
    end
    repeat (3) step();
    chk("rst_doutb0", doutb[0], 32'h0);
    chk("rst_valid0", {31'b0, doutb_valid[0]}, 32'h0);
    chk("rst_init_done0", {31'b0, init_done[0]}, 32'h0);
    chk("rst_doutb1", doutb[1], 32'h0);
    chk("rst_valid1", {31'b0, doutb_valid[1]}, 32'h0);
    chk("rst_init_done1", {31'b0, init_done[1]}, 32'h1);
    rst[1] = 1'b0;

    // Clear with junk traffic that must be ignored.
    rst[0] = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      ena[0] = 1'b1; wea[0] = 4'hF; addra[0] = 4'(i - 1); dina[0] = 32'hFFFFFFFF;
      enb[0] = 1'b1; addrb[0] = 4'(i - 1);
      step();
      chk("clear_init_done", {31'b0, init_done[0]}, {31'b0, i == 16});
    end
    ena[0] = 1'b0; wea[0] = 4'h0; enb[0] = 1'b0;
    for (int i = 0; i < 16; i++) rd(0, 4'(i), 32'h0);

    // Preload, stream back, then check hold.
    for (int i = 0; i < 16; i++) wr(0, 4'(i), 4'hF, 32'hA5000000 | i);
    for (int i = 0; i < 16; i++) rd(0, 4'(i), 32'hA5000000 | i);
    repeat (4) step();
    chk("hold_doutb", doutb[0], 32'hA500000F);
    chk("hold_valid", {31'b0, doutb_valid[0]}, 32'h0);

    // Reset, interrupt the clear at cnt=9, then let it complete.
    rst[0] = 1'b1; repeat (3) step(); rst[0] = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("midclear_init_done", {31'b0, init_done[0]}, 32'h0);
    end
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("reclear_init_done", {31'b0, init_done[0]}, {31'b0, i == 16});
    end
    for (int i = 0; i < 16; i++) rd(0, 4'(i), 32'h0);

    // Read-first instance: basic, lanes, collision.
    wr(0, 4'd5, 4'hF, 32'hDEADBEEF);
    rd(0, 4'd5, 32'hDEADBEEF);
    wr(0, 4'd3, 4'hF, 32'h11223344);
    wr(0, 4'd3, 4'b0101, 32'hAABBCCDD);
    rd(0, 4'd3, 32'h11BB33DD);
    wr(0, 4'd7, 4'hF, 32'h0);
    wr_rd(0, 4'd7, 4'hF, 32'hCAFEF00D, 32'h00000000);
    rd(0, 4'd7, 32'hCAFEF00D);

    // Write-first instance: basic, collision, partial-lane collision.
    wr(1, 4'd5, 4'hF, 32'hDEADBEEF);
    rd(1, 4'd5, 32'hDEADBEEF);
    wr(1, 4'd7, 4'hF, 32'h0);
    wr_rd(1, 4'd7, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D);
    rd(1, 4'd7, 32'hCAFEF00D);
    wr(1, 4'd3, 4'hF, 32'h11223344);
    wr_rd(1, 4'd3, 4'b0101, 32'hAABBCCDD, 32'h11BB33DD);
    rd(1, 4'd3, 32'h11BB33DD);
    repeat (8) step();

    // Two reads in flight are dropped by reset.
    rd(1, 4'd5, 32'hDEADBEEF);
    rd(1, 4'd7, 32'hCAFEF00D);
    rst[1] = 1'b1;
    step();
    q1.delete();
    rst[1] = 1'b0;
    chk("flight_init_done1", {31'b0, init_done[1]}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("flight_doutb1", doutb[1], 32'h0);
    end

    for (int i = 0; i < 60 && (q0.size() + q1.size()) != 0; i++) step();
    chk("drain_pending", q0.size() + q1.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
